axi4_burst_responder: RTL
=========================

// Module: axi4_burst_responder
// PURPOSE
//  AXI4 full-protocol slave responder: the target end of the INCR burst traffic issued by the
//  master VIP agents on the S00_AXI side. Services one write or read burst at a time against an
//  internal word-addressed memory and returns B/R responses with ID echo. It is the synthesizable
//  backing store behind the RelationalCache slave port and the bench's loop-back target.
// PARAMETERS
//  C_S_AXI_ID_WIDTH    1   width of AWID/BID/ARID/RID
//  C_S_AXI_DATA_WIDTH  32  data width; only 32 supported, so one beat = 4 bytes
//  C_S_AXI_ADDR_WIDTH  8   byte address width; memory depth = 2^(C_S_AXI_ADDR_WIDTH-2) words
// PORTS
//  ACLK     in  1    clock, all logic rising-edge
//  ARESET   in  1    asynchronous, active-high reset
//  AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]  in   write address channel fields
//  AWVALID in 1 / AWREADY out 1                    write address handshake
//  WDATA[32]/WSTRB[4]/WLAST in, WVALID in 1 / WREADY out 1   write data channel
//  BID out ID / BRESP out 2 / BVALID out 1 / BREADY in 1     write response channel
//  ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]  in   read address channel fields
//  ARVALID in 1 / ARREADY out 1                    read address handshake
//  RID out ID / RDATA out 32 / RRESP out 2 / RLAST out 1 / RVALID out 1 / RREADY in 1  read data
// BEHAVIOUR
//  - Reset: state IDLE; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, RID, BRESP,
//    RRESP, RDATA = 0; write-priority flag = write. Memory contents are NOT cleared. Reset
//    mid-burst abandons the burst; no B/R is issued for it afterwards.
//  - FSM: IDLE -> WR_DATA -> WR_RESP -> IDLE; IDLE -> RD_DATA -> IDLE. One burst outstanding.
//  - IDLE: AWREADY = AWVALID & (~ARVALID | prio_wr); ARREADY = ARVALID & (~AWVALID | ~prio_wr).
//    Both valid in the same cycle: grant per prio flag, then flag toggles (round-robin); a lone
//    request does not toggle it. On handshake latch ID, addr, len, size, burst.
//  - Address: word index = addr[ADDR_WIDTH-1:2], low 2 bits ignored. INCR: +1 per beat, wraps
//    modulo depth. FIXED: constant. WRAP: legal only for len 1/3/7/15; index wraps inside an
//    aligned (len+1)-word window. Burst type 2'b11 or an illegal WRAP len -> SLVERR.
//  - Size check: AxSIZE != 3'd2 -> SLVERR. Any SLVERR burst: writes suppressed, reads
//    return RDATA = 0; beat count and RLAST timing unchanged.
//  - WR_DATA: WREADY = 1. Each W handshake writes the byte lanes with WSTRB[i]=1 at the current
//    index. Beats past len+1 are accepted but not written. Exit on WLAST handshake; if beat
//    count != len+1 at WLAST -> BRESP = SLVERR.
//  - WR_RESP: BVALID = 1, BID = latched AWID, BRESP = 2'b00 (OKAY) or 2'b10 (SLVERR); held
//    stable until BREADY; return to IDLE the cycle after the B handshake.
//  - RD_DATA: RVALID rises 1 cycle after AR handshake (registered memory read). While RREADY=1
//    one beat per cycle, back-to-back. RVALID=1 & RREADY=0: RDATA/RRESP/RLAST/RID hold stable.
//    RLAST = 1 on beat len+1 only; RID = latched ARID; RVALID falls after the last handshake.
//  - AWREADY/ARREADY = 0 outside IDLE; no write/read overlap, so no read-during-write hazard.
//  - len = 255 (256 beats) supported; beat counter is 9 bits.
// TESTING
//  1 INCR write len=7 addr 0x00 data 1..8, then INCR read len=7 addr 0x00 -> RDATA 1..8,
//    RRESP OKAY, RLAST only on beat 8, BRESP OKAY, BID/RID echo AWID/ARID.
//  2 Write 0xFFFFFFFF to 0x08, then 0xAAAA5555 with WSTRB=4'b0011 -> read 0x08 = 0xFFFF5555.
//  3 WRAP len=3 read at 0x08 after test 1 -> RDATA 3,4,1,2; WRAP len=2 -> SLVERR, RDATA 0.
//  4 AWVALID & ARVALID same cycle twice -> first write granted, next read granted;
//    RREADY toggled 1/0 every cycle -> each RDATA held until handshake, 8 beats delivered.
//  5 AWSIZE=1 write of 0xDEADBEEF at 0x10 -> BRESP SLVERR, read 0x10 unchanged; WLAST on
//    beat 3 of len=7 -> BRESP SLVERR, FSM back in IDLE.
//  6 ARESET pulsed during read beat 4 of 8 -> RVALID=0 next edge, ARREADY available; earlier
//    written data still readable.

Source files
------------

// File: rtl/axi4_burst_responder.sv
// rtl/axi4_burst_responder.sv - AXI4 slave burst responder backed by a word-addressed memory
// Purpose: services one AXI4 write or read burst at a time (INCR/FIXED/WRAP) against an
//   internal 2^(C_S_AXI_ADDR_WIDTH-2) x 32-bit memory, echoing IDs on B/R.
// Ports:
//   ACLK, ARESET                     clock, asynchronous active-high reset
//   AW* / AWVALID / AWREADY          write address channel
//   WDATA / WSTRB / WLAST / WVALID / WREADY    write data channel
//   BID / BRESP / BVALID / BREADY    write response channel
//   AR* / ARVALID / ARREADY          read address channel
//   RID / RDATA / RRESP / RLAST / RVALID / RREADY  read data channel
module axi4_burst_responder #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [2:0]                      ARSIZE,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int IW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t                        state;
  logic                          prio_wr;
  logic [IW-1:0]                 idx;
  logic [8:0]                    cnt;
  logic [7:0]                    b_len;
  logic [1:0]                    b_burst;
  logic                          b_err;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0] aw_idx, ar_idx;
  logic          aw_err, ar_err, mem_we;
  logic          unused_addr_bits;

  // Byte offset within a word is irrelevant for a 32-bit-only slave.
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    return (size != 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                  (len == 8'd7) || (len == 8'd15)));
  endfunction

  // WRAP: len+1 is a power of two, so len itself is the in-window offset mask.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur, input logic [1:0] burst,
                                             input logic [7:0] len);
    logic [IW-1:0] mask;
    mask = IW'(len);
    case (burst)
      2'b00:   return cur;
      2'b10:   return (cur & ~mask) | ((cur + 1'b1) & mask);
      default: return cur + 1'b1;
    endcase
  endfunction

  assign aw_idx  = AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx  = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_err  = burst_err(AWSIZE, AWBURST, AWLEN);
  assign ar_err  = burst_err(ARSIZE, ARBURST, ARLEN);

  // Round-robin arbitration only matters when both address channels request together.
  assign AWREADY = (state == IDLE) && AWVALID && (!ARVALID || prio_wr);
  assign ARREADY = (state == IDLE) && ARVALID && (!AWVALID || !prio_wr);
  assign WREADY  = (state == WR_DATA);

  // Beats beyond len+1 are accepted but dropped.
  assign mem_we  = (state == WR_DATA) && WVALID && !b_err && (cnt <= {1'b0, b_len});

  // Memory has no reset so contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
        if (WSTRB[i]) mem[idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      prio_wr <= 1'b1;
      idx     <= '0;
      cnt     <= '0;
      b_len   <= '0;
      b_burst <= '0;
      b_err   <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      BVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
      RVALID  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AWVALID && ARVALID) prio_wr <= !prio_wr;
          if (AWREADY) begin
            BID     <= AWID;
            idx     <= aw_idx;
            b_len   <= AWLEN;
            b_burst <= AWBURST;
            b_err   <= aw_err;
            cnt     <= '0;
            state   <= WR_DATA;
          end else if (ARREADY) begin
            // First beat is fetched here so RVALID rises the cycle after the handshake.
            RID     <= ARID;
            RDATA   <= ar_err ? '0 : mem[ar_idx];
            RRESP   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            RLAST   <= (ARLEN == 8'd0);
            RVALID  <= 1'b1;
            idx     <= next_idx(ar_idx, ARBURST, ARLEN);
            b_len   <= ARLEN;
            b_burst <= ARBURST;
            b_err   <= ar_err;
            cnt     <= '0;
            state   <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (WVALID) begin
            idx <= next_idx(idx, b_burst, b_len);
            cnt <= cnt + 9'd1;
            if (WLAST) begin
              // cnt still holds the index of this final beat, so len+1 beats means cnt == len.
              BRESP  <= (b_err || (cnt != {1'b0, b_len})) ? RESP_SLVERR : RESP_OKAY;
              BVALID <= 1'b1;
              state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID <= 1'b0;
              RLAST  <= 1'b0;
              state  <= IDLE;
            end else begin
              RDATA <= b_err ? '0 : mem[idx];
              idx   <= next_idx(idx, b_burst, b_len);
              cnt   <= cnt + 9'd1;
              RLAST <= ((cnt + 9'd1) == {1'b0, b_len});
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
